// File: rtl/dct2_seq_pkg.sv
// dct2_seq_pkg: state encodings, size codes and size decode shared by the
// 2D DCT pass sequencer and its testbench.
package dct2_seq_pkg;

    localparam int MAX_N = 32;
    localparam int CW    = $clog2(MAX_N);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROW     = 3'd1,
        ST_DRAIN_R = 3'd2,
        ST_COL     = 3'd3,
        ST_DRAIN_C = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

    localparam logic [1:0] SZ4  = 2'b00;
    localparam logic [1:0] SZ8  = 2'b01;
    localparam logic [1:0] SZ16 = 2'b10;
    localparam logic [1:0] SZ32 = 2'b11;

    // One extra bit so that Nd = MAX_N itself is representable.
    function automatic logic [CW:0] size_code_to_n(input logic [1:0] code);
        logic [CW:0] n;
        n = (CW+1)'(4);
        return n << code;
    endfunction

endpackage

// File: rtl/dct2_2d_seq_if.sv
// dct2_2d_seq_if: request, core-handshake and buffer-control signals of the
// DCT pass sequencer; 'master' is the sequencer side, 'slave' its environment.
interface dct2_2d_seq_if #(
    parameter int CW = 5
);
    logic          blk_valid;
    logic [1:0]    blk_size;
    logic          blk_ready;
    logic          core_start;
    logic [1:0]    core_N;
    logic          core_read;
    logic          core_write;
    logic          src_rd_en;
    logic [CW-1:0] src_addr;
    logic          dst_wr_en;
    logic [CW-1:0] dst_addr;
    logic          pass;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  blk_valid, blk_size, core_read, core_write,
        output blk_ready, core_start, core_N, src_rd_en, src_addr,
               dst_wr_en, dst_addr, pass, busy, done, err
    );

    modport slave (
        output blk_valid, blk_size, core_read, core_write,
        input  blk_ready, core_start, core_N, src_rd_en, src_addr,
               dst_wr_en, dst_addr, pass, busy, done, err
    );
endinterface

// File: rtl/dct2_seq_pass_cnt.sv
// dct2_seq_pass_cnt: paired feed/output counters for one DCT pass, each
// compared against the active size before it is allowed to advance.
module dct2_seq_pass_cnt #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_in_inc,
    input  logic          i_out_inc,
    input  logic [CW:0]   i_nd,
    output logic [CW-1:0] o_in_addr,
    output logic [CW-1:0] o_out_addr,
    output logic          o_in_lt,
    output logic          o_out_lt,
    output logic          o_in_last,
    output logic          o_out_last
);
    logic [CW:0] r_in_cnt;
    logic [CW:0] r_out_cnt;
    logic [CW:0] w_nd_m1;

    assign w_nd_m1    = i_nd - (CW+1)'(1);
    assign o_in_lt    = (r_in_cnt < i_nd);
    assign o_out_lt   = (r_out_cnt < i_nd);
    assign o_in_last  = (r_in_cnt == w_nd_m1);
    assign o_out_last = (r_out_cnt == w_nd_m1);
    assign o_in_addr  = r_in_cnt[CW-1:0];
    assign o_out_addr = r_out_cnt[CW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (i_clr) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (i_in_inc && o_in_lt)
                r_in_cnt <= r_in_cnt + (CW+1)'(1);
            if (i_out_inc && o_out_lt)
                r_out_cnt <= r_out_cnt + (CW+1)'(1);
        end
    end
endmodule

// File: rtl/dct2_2d_seq.sv
// dct2_2d_seq: row-pass / column-pass sequencer for the 2D DCT-II core.
// Define DCT2_SEQ_PERF_EN to add the cycles_last accept-to-DONE counter port.
module dct2_2d_seq
    import dct2_seq_pkg::*;
#(
    parameter int MAX_N = 32,
    parameter int CW    = $clog2(MAX_N)
) (
    input  logic          clk,
    input  logic          reset,
    dct2_2d_seq_if.master bus
`ifdef DCT2_SEQ_PERF_EN
    ,
    output logic [15:0]   cycles_last
`endif
);
    seq_state_t    r_state;
    logic [1:0]    r_code;
    logic          r_blk_ready;
    logic          r_core_start;
    logic          r_pass;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic [CW:0]   w_nd;
    logic [CW-1:0] w_in_addr;
    logic [CW-1:0] w_out_addr;
    logic          w_in_lt, w_out_lt, w_in_last, w_out_last;
    logic          w_feed, w_wr_win, w_drain;
    logic          w_rd_ok, w_wr_ok, w_accept;
    logic          w_feed_end, w_pass_end, w_clr;

    assign w_nd = (CW+1)'(size_code_to_n(r_code));

    // A pass ends on its last output write; the drain also exits if the
    // outputs already completed while feeding was still going on.
    always_comb begin
        w_feed     = (r_state == ST_ROW) || (r_state == ST_COL);
        w_drain    = (r_state == ST_DRAIN_R) || (r_state == ST_DRAIN_C);
        w_wr_win   = w_feed || w_drain;
        w_rd_ok    = bus.core_read && w_feed && w_in_lt;
        w_wr_ok    = bus.core_write && w_wr_win && w_out_lt;
        w_accept   = bus.blk_valid && r_blk_ready;
        w_feed_end = w_rd_ok && w_in_last;
        w_pass_end = w_drain && (!w_out_lt || (w_wr_ok && w_out_last));
        w_clr      = w_accept || w_pass_end;
    end

    dct2_seq_pass_cnt #(.CW(CW)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_clr),
        .i_in_inc   (w_rd_ok),
        .i_out_inc  (w_wr_ok),
        .i_nd       (w_nd),
        .o_in_addr  (w_in_addr),
        .o_out_addr (w_out_addr),
        .o_in_lt    (w_in_lt),
        .o_out_lt   (w_out_lt),
        .o_in_last  (w_in_last),
        .o_out_last (w_out_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_code       <= SZ4;
            r_blk_ready  <= 1'b1;
            r_core_start <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((bus.core_read && !w_rd_ok) || (bus.core_write && !w_wr_ok))
                r_err <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_code       <= bus.blk_size;
                    r_state      <= ST_ROW;
                    r_blk_ready  <= 1'b0;
                    r_busy       <= 1'b1;
                    r_core_start <= 1'b1;
                    r_pass       <= 1'b0;
                end
                ST_ROW: if (w_feed_end) begin
                    r_state      <= ST_DRAIN_R;
                    r_core_start <= 1'b0;
                end
                // Column feeding waits for the last row output (transpose dependency).
                ST_DRAIN_R: if (w_pass_end) begin
                    r_state      <= ST_COL;
                    r_pass       <= 1'b1;
                    r_core_start <= 1'b1;
                end
                ST_COL: if (w_feed_end) begin
                    r_state      <= ST_DRAIN_C;
                    r_core_start <= 1'b0;
                end
                ST_DRAIN_C: if (w_pass_end) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_pass      <= 1'b0;
                    r_blk_ready <= 1'b1;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_pass       <= 1'b0;
                    r_core_start <= 1'b0;
                    r_blk_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.blk_ready  = r_blk_ready;
    assign bus.core_start = r_core_start;
    assign bus.core_N     = r_code;
    assign bus.src_rd_en  = w_rd_ok;
    assign bus.src_addr   = w_in_addr;
    assign bus.dst_wr_en  = w_wr_ok;
    assign bus.dst_addr   = w_out_addr;
    assign bus.pass       = r_pass;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

`ifdef DCT2_SEQ_PERF_EN
    logic [15:0] r_perf_cnt;
    logic [15:0] r_cycles_last;

    // Counts edges from the accept edge up to and including the edge into DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_cnt    <= '0;
            r_cycles_last <= '0;
        end else if (w_accept) begin
            r_perf_cnt <= 16'd1;
        end else if ((r_state == ST_DRAIN_C) && w_pass_end) begin
            r_cycles_last <= (r_perf_cnt == 16'hFFFF) ? 16'hFFFF : r_perf_cnt + 16'd1;
        end else if (r_busy && (r_perf_cnt != 16'hFFFF)) begin
            r_perf_cnt <= r_perf_cnt + 16'd1;
        end
    end

    assign cycles_last = r_cycles_last;
`endif
endmodule

// File: tb/tb_dct2_2d_seq.sv
// tb_dct2_2d_seq: randomized core/requester model driving dct2_2d_seq, checked
// every cycle against a transaction-level model of the two-pass sequence.
module tb_dct2_2d_seq;

    logic clk;
    logic reset;

    dct2_2d_seq_if #(.CW(5)) bif ();

`ifdef DCT2_SEQ_PERF_EN
    logic [15:0] cyclesLast;
`endif

    dct2_2d_seq #(.MAX_N(32), .CW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
`ifdef DCT2_SEQ_PERF_EN
        ,
        .cycles_last (cyclesLast)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: what the sequencer should be showing this cycle.
    bit         mBusy, mReady, mStart, mPass, mDone, mErr;
    logic [1:0] mCode;
    int         mNd, rdCnt, wrCnt, acceptCyc, mCycLast;

    // Stimulus controls.
    int         lat, stallMode, holdEn, holdLeft, reqLeft, accCount, doneCount;
    logic [1:0] code0, code1;
    bit         strayWrite;
    int         wq[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: saw %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy = 0; mReady = 1; mStart = 0; mPass = 0; mDone = 0; mErr = 0;
        mCode = 2'b00; mNd = 4; rdCnt = 0; wrCnt = 0; mCycLast = 0;
        holdLeft = 0;
        wq.delete();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_blk_ready"}, bif.blk_ready, 1);
        checkOutput({tag, "_busy"}, bif.busy, 0);
        checkOutput({tag, "_core_start"}, bif.core_start, 0);
        checkOutput({tag, "_core_N"}, bif.core_N, 0);
        checkOutput({tag, "_src_rd_en"}, bif.src_rd_en, 0);
        checkOutput({tag, "_src_addr"}, bif.src_addr, 0);
        checkOutput({tag, "_dst_wr_en"}, bif.dst_wr_en, 0);
        checkOutput({tag, "_dst_addr"}, bif.dst_addr, 0);
        checkOutput({tag, "_pass"}, bif.pass, 0);
        checkOutput({tag, "_done"}, bif.done, 0);
        checkOutput({tag, "_err"}, bif.err, 0);
`ifdef DCT2_SEQ_PERF_EN
        checkOutput({tag, "_cycles_last"}, cyclesLast, 0);
`endif
    endtask

    // Plays requester and core: reads while core_start is up (with optional
    // stalls), writes back each accepted read after a fixed latency.
    task automatic applyStimulus();
        bit go;
        case (stallMode)
            1:       go = ((cyc % 2) == 0);
            2:       go = ($urandom_range(0, 1) == 1);
            default: go = 1'b1;
        endcase
        bif.blk_valid = (reqLeft > 0);
        bif.blk_size  = (accCount == 0) ? code0 : code1;
        bif.core_read = (bif.core_start & go) | (holdLeft > 0);
        if (holdLeft > 0) holdLeft--;
        bif.core_write = strayWrite;
        if (wq.size() > 0 && wq[0] == cyc) begin
            bif.core_write = 1'b1;
            void'(wq.pop_front());
        end
    endtask

    task automatic sampleCycle();
        bit expRd, expWr;
        expRd = bif.core_read & mStart;
        expWr = bif.core_write & mBusy & !mDone & (wrCnt < mNd);
        checkOutput("src_rd_en", bif.src_rd_en, expRd);
        checkOutput("dst_wr_en", bif.dst_wr_en, expWr);
        if (expRd) checkOutput("src_addr", bif.src_addr, rdCnt);
        if (expWr) checkOutput("dst_addr", bif.dst_addr, wrCnt);
        checkOutput("core_start", bif.core_start, mStart);
        checkOutput("busy", bif.busy, mBusy);
        checkOutput("blk_ready", bif.blk_ready, mReady);
        checkOutput("pass", bif.pass, mPass);
        checkOutput("done", bif.done, mDone);
        checkOutput("err", bif.err, mErr);
        checkOutput("core_N", bif.core_N, mCode);
`ifdef DCT2_SEQ_PERF_EN
        checkOutput("cycles_last", cyclesLast, mCycLast);
`endif
        if ((bif.core_read & !expRd) | (bif.core_write & !expWr)) mErr = 1;
        if (mDone) begin
            mDone = 0; mBusy = 0; mPass = 0; mReady = 1;
            doneCount++;
        end else if (mReady & bif.blk_valid) begin
            mReady = 0; mBusy = 1; mStart = 1; mPass = 0;
            mCode = bif.blk_size;
            mNd = 4 << bif.blk_size;
            rdCnt = 0; wrCnt = 0;
            acceptCyc = cyc;
            reqLeft--;
            accCount++;
        end else if (mBusy) begin
            if (expRd) begin
                rdCnt++;
                wq.push_back(cyc + lat);
                if (rdCnt == mNd) begin
                    mStart = 0;
                    if (holdEn != 0 && !mPass) holdLeft = 5;
                end
            end
            if (expWr) begin
                wrCnt++;
                if (wrCnt == mNd) begin
                    if (!mPass) begin
                        mPass = 1; mStart = 1; rdCnt = 0; wrCnt = 0;
                    end else begin
                        mDone = 1;
                        mCycLast = cyc + 1 - acceptCyc;
                    end
                end
            end
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
        applyStimulus();
        @(negedge clk);
        sampleCycle();
    endtask

    task automatic runTraffic(input int nBlk, input logic [1:0] c0, input logic [1:0] c1,
                              input int latency, input int stall, input int hold,
                              input bit stopAtDrain);
        int  n;
        bit  reached;
        reqLeft = nBlk; accCount = 0; doneCount = 0;
        code0 = c0; code1 = c1; lat = latency; stallMode = stall; holdEn = hold;
        reached = 0;
        n = 0;
        while (n < 3000) begin
            stepCycle();
            n++;
            if (stopAtDrain && mBusy && !mPass && rdCnt == mNd) begin
                reached = 1;
                break;
            end
            if (!stopAtDrain && doneCount == nBlk) break;
        end
        if (stopAtDrain) begin
            checkOutput("reach_drain_r", reached, 1);
        end else begin
            checkOutput("blocks_done", doneCount, nBlk);
            stepCycle();
            stepCycle();
        end
    endtask

    initial begin
        logic [1:0] rc;
        reset = 1'b1;
        bif.blk_valid = 0; bif.blk_size = 0; bif.core_read = 0; bif.core_write = 0;
        strayWrite = 0; stallMode = 0; reqLeft = 0; accCount = 0; lat = 3; holdEn = 0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetState("por");
        reset = 1'b0;

        runTraffic(1, 2'b00, 2'b00, 3, 0, 0, 0);
        runTraffic(1, 2'b11, 2'b11, 2, 1, 0, 0);
        runTraffic(1, 2'b00, 2'b00, 6, 0, 1, 0);
        runTraffic(2, 2'b01, 2'b10, 3, 0, 0, 0);

        runTraffic(1, 2'b11, 2'b11, 6, 0, 0, 1);
        @(posedge clk);
        #1;
        bif.blk_valid = 0; bif.core_read = 0; bif.core_write = 0;
        reset = 1'b1;
        #1;
        checkResetState("async");
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        strayWrite = 1;
        stepCycle();
        strayWrite = 0;
        stepCycle();

        runTraffic(1, 2'b01, 2'b01, 3, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            rc = 2'($urandom_range(0, 3));
            runTraffic(1, rc, rc, int'($urandom_range(1, 5)), 2, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
